p2s_serializer: RTL

//  Parametrised parallel-to-serial shifter with valid/ready load handshake,
//  bit-rate enable, selectable bit order and a one-cycle word-complete latch

---
 rtl/p2s_pkg.sv | 16 +
 rtl/p2s_serializer_if.sv | 24 ++
 rtl/p2s_bit_counter.sv | 30 +++
 rtl/p2s_serializer.sv | 96 +++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_serializer block: FSM state encoding and
// the frame-length contribution of the optional parity slot.
// Configuration macro: P2S_SERIALIZER_PARITY_EN (adds one even-parity bit per frame).
package p2s_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

`ifdef P2S_SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/p2s_serializer_if.sv
// Load handshake plus serial-side signals of the p2s_serializer.
// Ports: p_in/p_valid/bit_en driven by the producer (master);
//        p_ready/s_out/latch/busy driven by the serializer (slave).
interface p2s_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] p_in;
  logic             p_valid;
  logic             p_ready;
  logic             bit_en;
  logic             s_out;
  logic             latch;
  logic             busy;

  modport master (
    output p_in, p_valid, bit_en,
    input  p_ready, s_out, latch, busy
  );

  modport slave (
    input  p_in, p_valid, bit_en,
    output p_ready, s_out, latch, busy
  );
endinterface

// File: rtl/p2s_bit_counter.sv
// Saturating bit counter for the serializer: counts driven frame bits.
// Ports: clk/rst (async active-high), clr (restart at 0), en (count one bit),
//        tc (high once N bits have been counted; counter then holds).
module p2s_bit_counter #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(N));

  // Holding at N keeps the counter from ever wrapping even if en stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial shifter with valid/ready load, bit-rate enable,
// selectable bit order and a one-clock latch strobe after each frame.
// Ports: clk, rst (async active-high, aborts a frame), bus (slave modport:
//        p_in/p_valid/p_ready load side, bit_en/s_out/latch/busy serial side).
// Configuration macro: P2S_SERIALIZER_PARITY_EN appends an even-parity bit.
module p2s_serializer
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  p2s_serializer_if.slave   bus
);

  localparam int FRAME = WIDTH + PARITY_BITS;
  localparam int CW    = $clog2(WIDTH + 2);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [FRAME-1:0] shreg;
  logic [FRAME-1:0] load_word;
  logic             s_out_q;
  logic             load;
  logic             shift;
  logic             tc;

  // The parity bit rides in the shift register as the last slot, so the
  // datapath needs no separate mux on the bit count.
`ifdef P2S_SERIALIZER_PARITY_EN
  assign load_word = LSB_FIRST ? {^bus.p_in, bus.p_in} : {bus.p_in, ^bus.p_in};
`else
  assign load_word = bus.p_in;
`endif

  assign load  = (state == ST_IDLE) && bus.p_valid;
  assign shift = (state == ST_SHIFT) && bus.bit_en && !tc;

  p2s_bit_counter #(
    .N  (FRAME),
    .CW (CW)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (shift),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The frame ends on the first bit_en edge after the last bit was driven,
  // so the last bit stays on s_out for a full bit period.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.p_valid)           state_nxt = ST_SHIFT;
      ST_SHIFT: if (bus.bit_en && tc)      state_nxt = ST_LATCH;
      ST_LATCH:                            state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.p_ready = (state == ST_IDLE);
    bus.busy    = (state != ST_IDLE);
    bus.latch   = (state == ST_LATCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      s_out_q <= 1'b0;
    end else if (load) begin
      shreg <= load_word;
    end else if (shift) begin
      if (LSB_FIRST) begin
        s_out_q <= shreg[0];
        shreg   <= {1'b0, shreg[FRAME-1:1]};
      end else begin
        s_out_q <= shreg[FRAME-1];
        shreg   <= {shreg[FRAME-2:0], 1'b0};
      end
    end
  end

  assign bus.s_out = s_out_q;

endmodule
